// File: rtl/axis_latency_monitor.sv
// Passive request/response latency monitor for two AXI-Stream taps.
// Timestamps request packets, matches responses in order, keeps latency statistics.
module axis_latency_monitor #(
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int SUM_W   = 48,
    parameter int MAX_OUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_tvalid,
    input  logic                       req_tready,
    input  logic                       req_tlast,
    input  logic                       rsp_tvalid,
    input  logic                       rsp_tready,
    input  logic                       rsp_tlast,
    input  logic                       clr,
    output logic                       req_allow,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic [CNT_W-1:0]           pkt_tx_cnt,
    output logic [CNT_W-1:0]           pkt_rx_cnt,
    output logic                       lat_valid,
    output logic [CNT_W-1:0]           lat_last,
    output logic [CNT_W-1:0]           lat_min,
    output logic [CNT_W-1:0]           lat_max,
    output logic [SUM_W-1:0]           lat_sum,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic             req_beat, req_end, rsp_end;
    logic             req_in_pkt;
    logic [CNT_W-1:0] now, start_ts, push_ts, head_ts, sample;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, do_push, do_pop;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] mem [DEPTH];

    assign req_beat = req_tvalid & req_tready;
    assign req_end  = req_beat & req_tlast;
    assign rsp_end  = rsp_tvalid & rsp_tready & rsp_tlast;

    // A single-beat packet has no latched start, so it stamps with the current cycle.
    assign push_ts = req_in_pkt ? start_ts : now;

    // Emptiness comes from the registered count, so a same-cycle push can never be popped.
    assign fifo_empty = (outstanding == '0);
    assign fifo_full  = (outstanding == OW'(DEPTH));
    assign do_pop     = rsp_end & ~fifo_empty;
    assign do_push    = req_end & (~fifo_full | do_pop);

    assign head_ts  = mem[rd_ptr];
    assign sample   = now - head_ts;
    assign sum_ext  = {1'b0, lat_sum} + {{(SUM_W+1-CNT_W){1'b0}}, sample};
    assign sum_next = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

    assign req_allow = (outstanding < OW'(MAX_OUT));

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_ts;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now         <= '0;
            req_in_pkt  <= 1'b0;
            start_ts    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            now <= now + 1'b1;
            if (req_beat) begin
                req_in_pkt <= ~req_tlast;
                if (!req_in_pkt) start_ts <= now;
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + OW'(do_push) - OW'(do_pop);
        end
    end

    // Statistics and sticky flags; clr takes priority over any same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_tx_cnt <= '0;
            pkt_rx_cnt <= '0;
            lat_valid  <= 1'b0;
            lat_last   <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            lat_sum    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clr) begin
            pkt_tx_cnt <= '0;
            pkt_rx_cnt <= '0;
            lat_valid  <= 1'b0;
            lat_last   <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            lat_sum    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            lat_valid <= do_pop;
            if (req_end) pkt_tx_cnt <= pkt_tx_cnt + 1'b1;
            if (rsp_end) pkt_rx_cnt <= pkt_rx_cnt + 1'b1;
            if (req_end && fifo_full && !do_pop) overflow <= 1'b1;
            if (rsp_end && fifo_empty) underflow <= 1'b1;
            if (do_pop) begin
                lat_last <= sample;
                lat_sum  <= sum_next;
                if (sample < lat_min) lat_min <= sample;
                if (sample > lat_max) lat_max <= sample;
            end
        end
    end
endmodule

// File: tb/tb_axis_latency_monitor.sv
// Scoreboard bench for axis_latency_monitor: small DEPTH so full/overflow paths are reachable.
module tb_axis_latency_monitor;
    localparam int DEPTH = 4, CNT_W = 32, SUM_W = 48, MAX_OUT = 2;
    localparam int OW = $clog2(DEPTH+1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_tvalid = 0, req_tready = 0, req_tlast = 0;
    logic rsp_tvalid = 0, rsp_tready = 0, rsp_tlast = 0, clr = 0;
    logic req_allow, lat_valid, overflow, underflow;
    logic [OW-1:0] outstanding;
    logic [CNT_W-1:0] pkt_tx_cnt, pkt_rx_cnt, lat_last, lat_min, lat_max;
    logic [SUM_W-1:0] lat_sum;

    int total = 0, bad = 0, cyc = 0;
    int ts_q[$];
    int exp_q[$];
    bit m_in = 0;
    int m_start = 0;

    axis_latency_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SUM_W(SUM_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast),
        .clr(clr), .req_allow(req_allow), .outstanding(outstanding),
        .pkt_tx_cnt(pkt_tx_cnt), .pkt_rx_cnt(pkt_rx_cnt), .lat_valid(lat_valid),
        .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every latency pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && lat_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: lat_valid with lat_last=%0d, none expected", lat_last);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (lat_last !== CNT_W'(e)) begin
                    bad++;
                    $display("FAIL sb_lat: got %0d want %0d", lat_last, e);
                end
            end
        end
    end

    // One clock of stimulus plus the reference model update for that edge.
    task automatic beat(input bit rv, input bit rl, input bit sv, input bit sl, input bit c);
        bit pop;
        int st, t;
        req_tvalid = rv; req_tready = 1'b1; req_tlast = rl;
        rsp_tvalid = sv; rsp_tready = 1'b1; rsp_tlast = sl;
        clr = c;
        @(posedge clk);
        #1;
        req_tvalid = 0; req_tlast = 0; rsp_tvalid = 0; rsp_tlast = 0; clr = 0;
        pop = sv && sl && ts_q.size() > 0;
        st = m_in ? m_start : cyc;
        if (rv && !m_in) m_start = cyc;
        if (pop) begin
            t = ts_q.pop_front();
            if (!c) exp_q.push_back(cyc - t);
        end
        if (rv && rl && (ts_q.size() < DEPTH)) ts_q.push_back(st);
        if (rv) m_in = !rl;
    endtask

    task automatic wait_until(input int t);
        while (cyc + 1 < t) beat(0, 0, 0, 0, 0);
    endtask

    task automatic req4();
        beat(1, 0, 0, 0, 0); beat(1, 0, 0, 0, 0); beat(1, 0, 0, 0, 0); beat(1, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        total++; if (outstanding !== '0) begin bad++; $display("FAIL rst_out: got %0d want 0", outstanding); end
        total++; if (req_allow !== 1'b1) begin bad++; $display("FAIL rst_allow: got %0b want 1", req_allow); end
        total++; if (pkt_tx_cnt !== '0 || pkt_rx_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", pkt_tx_cnt, pkt_rx_cnt); end
        total++; if (lat_min !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_min: got %h want ffffffff", lat_min); end
        total++; if (lat_max !== '0 || lat_last !== '0 || lat_sum !== '0) begin bad++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", lat_max, lat_last, lat_sum); end
        total++; if (lat_valid !== 0 || overflow !== 0 || underflow !== 0) begin bad++; $display("FAIL rst_flags: got %b%b%b want 000", lat_valid, overflow, underflow); end
    endtask

    task automatic test_single();
        int b;
        b = cyc + 1;
        beat(1, 1, 0, 0, 0);
        total++; if (outstanding !== OW'(1)) begin bad++; $display("FAIL single_out1: got %0d want 1", outstanding); end
        wait_until(b + 15);
        beat(0, 0, 1, 1, 0);
        total++; if (outstanding !== '0) begin bad++; $display("FAIL single_out0: got %0d want 0", outstanding); end
        total++; if (lat_valid !== 1'b1 || lat_last !== 32'd15) begin bad++; $display("FAIL single_sample: got v=%b %0d want v=1 15", lat_valid, lat_last); end
        total++; if (lat_min !== 32'd15 || lat_max !== 32'd15 || lat_sum !== 48'd15) begin bad++; $display("FAIL single_stats: got %0d/%0d/%0d want 15/15/15", lat_min, lat_max, lat_sum); end
        beat(0, 0, 0, 0, 0);
        total++; if (lat_valid !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", lat_valid); end
        beat(0, 0, 0, 0, 1);
        total++; if (lat_min !== 32'hFFFF_FFFF || lat_sum !== '0) begin bad++; $display("FAIL clr_stats: got %h/%0d want ffffffff/0", lat_min, lat_sum); end
    endtask

    task automatic test_multi();
        int b;
        b = cyc + 1;
        req4();
        wait_until(b + 20); beat(0, 0, 1, 1, 0);
        wait_until(b + 24); req4();
        wait_until(b + 32); beat(0, 0, 1, 1, 0);
        wait_until(b + 33); req4();
        wait_until(b + 64); beat(0, 0, 1, 1, 0);
        total++; if (lat_min !== 32'd8 || lat_max !== 32'd31) begin bad++; $display("FAIL multi_minmax: got %0d/%0d want 8/31", lat_min, lat_max); end
        total++; if (lat_sum !== 48'd59) begin bad++; $display("FAIL multi_sum: got %0d want 59", lat_sum); end
        total++; if (pkt_tx_cnt !== 32'd3 || pkt_rx_cnt !== 32'd3) begin bad++; $display("FAIL multi_cnt: got %0d/%0d want 3/3", pkt_tx_cnt, pkt_rx_cnt); end
        beat(0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        int exp_out[5] = '{1, 2, 3, 4, 4};
        bit exp_allow[5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            beat(1, 1, 0, 0, 0);
            total++; if (outstanding !== OW'(exp_out[i]) || req_allow !== exp_allow[i]) begin
                bad++; $display("FAIL ovf_out%0d: got %0d allow=%b want %0d allow=%b", i, outstanding, req_allow, exp_out[i], exp_allow[i]);
            end
            total++; if (overflow !== (i == 4)) begin bad++; $display("FAIL ovf_flag%0d: got %b want %b", i, overflow, i == 4); end
        end
        total++; if (pkt_tx_cnt !== 32'd5) begin bad++; $display("FAIL ovf_tx: got %0d want 5", pkt_tx_cnt); end
    endtask

    task automatic test_full_simul();
        beat(0, 0, 0, 0, 1);
        beat(1, 1, 1, 1, 0);
        total++; if (outstanding !== OW'(DEPTH) || overflow !== 1'b0) begin bad++; $display("FAIL full_simul: got out=%0d ovf=%b want out=4 ovf=0", outstanding, overflow); end
        total++; if (lat_valid !== 1'b1 || pkt_rx_cnt !== 32'd1) begin bad++; $display("FAIL full_sample: got v=%b rx=%0d want v=1 rx=1", lat_valid, pkt_rx_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            beat(0, 0, 1, 1, 0);
            total++; if (outstanding !== OW'(DEPTH - 1 - i) || lat_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d: got out=%0d v=%b want out=%0d v=1", i, outstanding, lat_valid, DEPTH - 1 - i);
            end
        end
    endtask

    task automatic test_underflow();
        beat(0, 0, 0, 0, 1);
        beat(1, 1, 1, 1, 0);
        total++; if (underflow !== 1'b1 || outstanding !== OW'(1)) begin bad++; $display("FAIL unf: got unf=%b out=%0d want unf=1 out=1", underflow, outstanding); end
        total++; if (lat_valid !== 1'b0 || pkt_rx_cnt !== 32'd1) begin bad++; $display("FAIL unf_nosample: got v=%b rx=%0d want v=0 rx=1", lat_valid, pkt_rx_cnt); end
    endtask

    task automatic test_clr_reset();
        int b;
        beat(0, 0, 1, 1, 0);
        beat(1, 1, 0, 0, 0);
        beat(0, 0, 1, 1, 1);
        total++; if (outstanding !== '0 || lat_valid !== 1'b0) begin bad++; $display("FAIL clr_rsp: got out=%0d v=%b want out=0 v=0", outstanding, lat_valid); end
        total++; if (lat_min !== 32'hFFFF_FFFF || lat_max !== '0 || lat_last !== '0 || lat_sum !== '0) begin
            bad++; $display("FAIL clr_vals: got %h/%0d/%0d/%0d want ffffffff/0/0/0", lat_min, lat_max, lat_last, lat_sum);
        end
        total++; if (pkt_rx_cnt !== '0 || underflow !== 1'b0) begin bad++; $display("FAIL clr_cnt: got rx=%0d unf=%b want 0/0", pkt_rx_cnt, underflow); end
        beat(1, 1, 0, 0, 0);
        beat(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        ts_q.delete(); exp_q.delete(); m_in = 0;
        #1;
        total++; if (outstanding !== '0 || req_allow !== 1'b1 || pkt_tx_cnt !== '0) begin
            bad++; $display("FAIL midrst: got out=%0d allow=%b tx=%0d want 0/1/0", outstanding, req_allow, pkt_tx_cnt);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        b = cyc + 1;
        beat(1, 1, 0, 0, 0);
        wait_until(b + 5);
        beat(0, 0, 1, 1, 0);
        total++; if (lat_last !== 32'd5 || outstanding !== '0) begin bad++; $display("FAIL post_rst: got lat=%0d out=%0d want 5/0", lat_last, outstanding); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_full_simul();
        test_underflow();
        test_clr_reset();
        repeat (3) beat(0, 0, 0, 0, 0);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_missing: got %0d pending want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
